mmio_uart: RTL and testbench
============================

MMIO_UART -- requirements
Module: mmio_uart

Interface
REQ-001 SHALL have parameter DIV_RESET, default 234, meaning the reset baud divisor in clk cycles per bit (27 MHz / 115200).
REQ-002 SHALL have parameter TX_DEPTH, default 16, meaning the TX FIFO depth in bytes; the value is a power of 2 and at least 2.
REQ-003 SHALL have parameter RX_DEPTH, default 16, meaning the RX FIFO depth in bytes; the value is a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port sel, input, 1 bit: the peripheral is addressed (IO page decode done outside).
REQ-007 SHALL have port addr, input, 2 bits: register word offset (mem_addr[3:2]).
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port wmask, input, 4 bits: byte write mask; any bit set means write.
REQ-010 SHALL have port rstrb, input, 1 bit: read strobe.
REQ-011 SHALL have port rdata, output, 32 bits: registered read data.
REQ-012 SHALL have port rx, input, 1 bit: asynchronous serial in.
REQ-013 SHALL have port tx, output, 1 bit: serial out.
REQ-014 SHALL have port irq, output, 1 bit: interrupt; present only under UART_IRQ_EN.

Function
REQ-015 Register map SHALL be: 0 DATA, 1 STATUS, 2 DIV, 3 IRQ_EN.
REQ-016 A write to DATA (sel & wmask[0]) SHALL push wdata[7:0] into the TX FIFO; if the FIFO is full, the byte is dropped silently.
REQ-017 A read of DATA SHALL, on the next cycle, return {23'b0, valid, byte} in rdata, where valid = RX FIFO not empty, and SHALL pop the FIFO only when it is non-empty.
REQ-018 A read of STATUS SHALL return {26'b0, frame_err, rx_overrun, rx_full, rx_empty, tx_full, tx_empty} in bits [5:0].
REQ-019 A write to STATUS SHALL clear each of bits 5 and 4 where wdata holds 1 in that bit (write-1-to-clear).
REQ-020 DIV SHALL be a 16-bit read/write register; written values below 4 are stored as 4, and a new value takes effect at the next bit boundary.
REQ-021 rdata SHALL update only in the cycle after sel & rstrb (1-cycle latency) and SHALL otherwise hold its value.
REQ-022 The TX FSM SHALL have states IDLE, START, DATA, STOP; tx is 1 in IDLE and STOP, 0 in START, and carries data LSB first in DATA; each bit lasts DIV cycles.
REQ-023 In IDLE with the TX FIFO non-empty, the TX FSM SHALL pop one byte and enter START on the next cycle.
REQ-024 At the end of STOP, the TX FSM SHALL go directly to START if the FIFO is non-empty (back-to-back frames); otherwise it goes to IDLE.
REQ-025 rx SHALL pass through a 2-flop synchroniser.
REQ-026 The RX FSM SHALL have states IDLE, START, DATA, STOP; a synchronised 1->0 edge in IDLE enters START.
REQ-027 In START, the RX FSM SHALL sample at DIV/2 cycles; a sample of 1 returns to IDLE (glitch rejection), otherwise the FSM enters DATA.
REQ-028 In DATA, the RX FSM SHALL take 8 samples spaced DIV cycles apart.
REQ-029 At the stop sample, a 1 SHALL push the byte to the RX FIFO, or set rx_overrun and drop the byte if the FIFO is full.
REQ-030 At the stop sample, a 0 SHALL set frame_err and drop the byte; the FSM then returns to IDLE.
REQ-031 A simultaneous RX push and CPU pop with the FIFO full SHALL succeed with no overrun; simultaneous push/pop on the TX FIFO likewise.
REQ-032 FIFO pointers SHALL be log2(depth)+1 bits and wrap modulo 2*depth; full = MSBs differ and LSBs equal.

Reset
REQ-033 While resetn=0 on a clk edge: FIFOs empty, both FSMs IDLE, tx=1, rdata=0, DIV=DIV_RESET, IRQ_EN=0, all flags 0, irq=0.
REQ-034 Reset during a frame SHALL abort it immediately; tx SHALL read 1 on the first cycle after reset.

Configuration
REQ-035 With UART_IRQ_EN defined: IRQ_EN[0] enables "RX not empty", IRQ_EN[1] enables "TX empty", IRQ_EN[2] enables "overrun or frame_err"; irq is the registered OR of the enabled conditions.
REQ-036 Without UART_IRQ_EN: the irq port and the IRQ_EN storage are absent, writes to offset 3 are ignored, and reads of offset 3 return 0.

Verification
REQ-037 Scenario: DIV=4, write DATA=0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, then idle 1.
REQ-038 Scenario: write 17 bytes 0x00..0x10 with TX_DEPTH=16 while tx is busy -> 0x00..0x0F transmitted back-to-back and 0x10 lost.
REQ-039 Scenario: drive a 0xA3 frame on rx at DIV=8 -> DATA read returns 0x1A3, and the next read returns 0x000.
REQ-040 Scenario: 17 rx frames with no reads -> STATUS bit4=1 and the first 16 bytes intact; then write STATUS=0x10 -> bit4=0.
REQ-041 Scenario: a 2-cycle rx low glitch at DIV=8 -> no push and rx_empty stays 1; a frame with stop bit 0 -> frame_err=1 and no push.
REQ-042 Scenario: under UART_IRQ_EN, set IRQ_EN=1 and receive 0x41 -> irq=1; read DATA -> irq=0 within 2 cycles.

Source files
------------

// File: rtl/mmio_uart.sv
// Memory-mapped UART: 8N1 transmitter/receiver with TX/RX FIFOs, programmable divisor.
// Define UART_IRQ_EN to add the IRQ_EN register and the irq output.
module mmio_uart #(
    parameter int unsigned DIV_RESET = 234,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rstrb,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        wr_en;
    logic        rd_en;
    logic [15:0] div_q;
    logic [15:0] div_m1;
    logic [15:0] half_m1;
    logic        frame_err;
    logic        rx_ovr;
    logic [5:0]  status;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign wr_en       = sel & (|wmask);
    assign rd_en       = sel & rstrb;
    assign div_m1      = div_q - 16'd1;
    assign half_m1     = (div_q >> 1) - 16'd1;
    assign unused_bits = ^wdata[31:16];

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr;
    logic [TX_AW:0] tx_rptr;
    logic           tx_empty;
    logic           tx_full;
    logic           tx_push;
    logic           tx_pop;
    logic [7:0]     tx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr[TX_AW-1:0]];
    assign tx_push  = sel & wmask[0] & (addr == 2'd0) & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + (TX_AW+1)'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + (TX_AW+1)'(1);
        end
    end

    // TX framing FSM
    tx_state_t  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    assign tx_pop = ~tx_empty &
                    ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == 16'd0)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx       <= 1'b0;
                        tx_cnt   <= div_m1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= div_m1;
                        tx       <= tx_shift[0];
                        tx_bit   <= 3'd0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div_m1;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx       <= tx_shift[1];
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            tx       <= 1'b0;
                            tx_cnt   <= div_m1;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr;
    logic [RX_AW:0] rx_rptr;
    logic           rx_empty;
    logic           rx_full;
    logic           rx_push;
    logic           rx_pop;
    logic [7:0]     rx_byte;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_s3;
    logic        rx_stop_hit;
    logic        rx_push_req;

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                         (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
    assign rx_byte     = rx_empty ? 8'd0 : rx_mem[rx_rptr[RX_AW-1:0]];
    assign rx_pop      = rd_en & (addr == 2'd0) & ~rx_empty;
    assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
    assign rx_push_req = rx_stop_hit & rx_s2;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + (RX_AW+1)'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + (RX_AW+1)'(1);
        end
    end

    // RX synchroniser (s1, s2) plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX framing FSM; samples at mid-bit, start bit re-checked to reject glitches
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= half_m1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= div_m1;
                            rx_bit   <= 3'd0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= div_m1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) rx_state <= RX_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle wins over the clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            if (rx_stop_hit && !rx_s2)                     frame_err <= 1'b1;
            else if (wr_en && (addr == 2'd1) && wdata[5])  frame_err <= 1'b0;
            if (rx_push_req && rx_full && !rx_pop)         rx_ovr    <= 1'b1;
            else if (wr_en && (addr == 2'd1) && wdata[4])  rx_ovr    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= 16'(DIV_RESET);
        end else if (wr_en && (addr == 2'd2)) begin
            div_q <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
        end
    end

`ifdef UART_IRQ_EN
    logic [2:0] irq_en;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_en <= 3'd0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (addr == 2'd3)) irq_en <= wdata[2:0];
            irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) |
                   (irq_en[2] & (rx_ovr | frame_err));
        end
    end
`endif

    assign status = {frame_err, rx_ovr, rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            2'd0: rd_mux = {23'd0, ~rx_empty, rx_byte};
            2'd1: rd_mux = {26'd0, status};
            2'd2: rd_mux = {16'd0, div_q};
`ifdef UART_IRQ_EN
            2'd3: rd_mux = {29'd0, irq_en};
`else
            2'd3: rd_mux = 32'd0;
`endif
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)    rdata <= 32'd0;
        else if (rd_en) rdata <= rd_mux;
    end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register access, TX framing/FIFO, RX framing, errors, reset abort.
module tb_mmio_uart;
    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] rdata;
    logic        rx;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  cap    [32];
    bit          cap_ok [32];
    bit          cap_found;
    logic [31:0] d;
    int          lows;

    mmio_uart dut (
        .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata),
        .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .rx(rx), .tx(tx)
`ifdef UART_IRQ_EN
        , .irq(irq)
`endif
    );

`ifndef UART_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        sel = 1'b1; addr = a; wdata = v; wmask = 4'hF;
        @(negedge clk);
        sel = 1'b0; wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        sel = 1'b1; addr = a; rstrb = 1'b1;
        @(negedge clk);
        sel = 1'b0; rstrb = 1'b0;
        v = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    // Waits for a start bit, then records nframes contiguous frames, one sample per cycle
    task automatic capture(input int div, input int nframes);
        logic v;
        cap_found = 1'b0;
        for (int i = 0; i < 4000 && !cap_found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) cap_found = 1'b1;
        end
        if (!cap_found) return;
        for (int f = 0; f < nframes; f++) begin
            cap_ok[f] = 1'b1;
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < div; s++) begin
                    if (!(f == 0 && b == 0 && s == 0)) @(negedge clk);
                    v = tx;
                    if (s == 0) cap[f][b] = v;
                    else if (v !== cap[f][b]) cap_ok[f] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; sel = 1'b0; addr = 2'd0; wdata = 32'd0; wmask = 4'h0;
        rstrb = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;

        bus_read(2'd1, d); check("reset_status", d, 32'h05);
        bus_read(2'd3, d); check("reset_irq_en", d, 32'h0);
        bus_read(2'd2, d); check("reset_div", d, 32'd234);
        bus_write(2'd2, 32'd2);
        idle(3);
        check("rdata_hold", rdata, 32'd234);
        bus_read(2'd2, d); check("div_clamp", d, 32'd4);
        bus_write(2'd3, 32'd7);
        bus_read(2'd3, d);
`ifdef UART_IRQ_EN
        check("irq_en_rw", d, 32'd7);
`else
        check("irq_en_absent", d, 32'd0);
`endif
        bus_write(2'd3, 32'd0);

        // Single frame 0x55 at DIV=4
        bus_write(2'd2, 32'd4);
        fork
            capture(4, 1);
            bus_write(2'd0, 32'h55);
        join
        check("tx55_found", {31'd0, cap_found}, 32'd1);
        check("tx55_frame", {21'd0, cap_ok[0], cap[0]}, {21'd0, 1'b1, 10'h2AA});
        idle(2);
        check("tx55_idle_a", {31'd0, tx}, 32'd1);
        idle(8);
        check("tx55_idle_b", {31'd0, tx}, 32'd1);

        // Primer byte occupies the shifter, then 17 writes overflow the 16-deep FIFO
        bus_write(2'd2, 32'd16);
        fork
            capture(16, 17);
            begin
                bus_write(2'd0, 32'hC3);
                for (int k = 0; k <= 16; k++) bus_write(2'd0, 32'(k));
                bus_read(2'd1, d);
                check("tx_full_status", d, 32'h06);
            end
        join
        check("burst_found", {31'd0, cap_found}, 32'd1);
        check("burst_primer", {21'd0, cap_ok[0], cap[0]}, {21'd0, 1'b1, 1'b1, 8'hC3, 1'b0});
        for (int f = 1; f <= 16; f++)
            check($sformatf("burst_frame%0d", f), {21'd0, cap_ok[f], cap[f]},
                  {21'd0, 1'b1, 1'b1, 8'(f - 1), 1'b0});
        lows = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("burst_0x10_dropped", 32'(lows), 32'd0);
        bus_read(2'd1, d); check("burst_status_end", d, 32'h05);

        // RX single frame at DIV=8
        bus_write(2'd2, 32'd8);
        send_rx(8'hA3, 8, 1'b1);
        idle(4);
        bus_read(2'd0, d); check("rx_a3", d, 32'h1A3);
        bus_read(2'd0, d); check("rx_empty_read", d, 32'h000);

        // 17 frames without reads: overrun, first 16 intact
        for (int k = 0; k < 17; k++) send_rx(8'(k * 13 + 5), 8, 1'b1);
        idle(4);
        bus_read(2'd1, d); check("overrun_status", d, 32'h19);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d); check("overrun_clear", d, 32'h09);
        for (int k = 0; k < 16; k++) begin
            bus_read(2'd0, d);
            check($sformatf("rx_fifo%0d", k), d, {23'd0, 1'b1, 8'(k * 13 + 5)});
        end
        bus_read(2'd1, d); check("rx_drained", d, 32'h05);

        // Glitch rejection, then framing error
        @(negedge clk); rx = 1'b0;
        idle(2); rx = 1'b1;
        idle(20);
        bus_read(2'd1, d); check("glitch_no_push", d, 32'h05);
        send_rx(8'h5A, 8, 1'b0);
        idle(4);
        bus_read(2'd1, d); check("frame_err_set", d, 32'h25);
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d); check("frame_err_clear", d, 32'h05);
        send_rx(8'h3C, 8, 1'b1);
        idle(4);
        bus_read(2'd0, d); check("rx_recover", d, 32'h13C);

`ifdef UART_IRQ_EN
        bus_write(2'd3, 32'd1);
        send_rx(8'h41, 8, 1'b1);
        idle(4);
        check("irq_rx_set", {31'd0, irq}, 32'd1);
        bus_read(2'd0, d); check("irq_rx_data", d, 32'h141);
        idle(2);
        check("irq_rx_clear", {31'd0, irq}, 32'd0);
        bus_write(2'd3, 32'd2);
        idle(2);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'd0);
`endif

        // Reset in the middle of a frame
        bus_write(2'd0, 32'h00);
        idle(10);
        check("midframe_low", {31'd0, tx}, 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("abort_stays_idle", 32'(lows), 32'd0);
        bus_read(2'd1, d); check("abort_status", d, 32'h05);
        bus_read(2'd2, d); check("abort_div", d, 32'd234);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
